instr_fetch_unit: RTL and testbench

//  Fetch front-end between the RISC-V core decode stage and the ROMEM instruction memory.

---
 rtl/instr_fetch_unit_pkg.sv | 20 ++
 rtl/instr_fetch_unit_fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 146 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch front-end.
//   ins_size      : default machine word width (PC and instruction)
//   fetch_state_t : fetch FSM states
//   fetch_entry_t : one prefetch queue entry, a fetched word tagged with its PC
package instr_fetch_unit_pkg;

  localparam int unsigned ins_size = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [ins_size-1:0] pc;
    logic [ins_size-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Prefetch queue: registered circular FIFO with synchronous flush.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   push_i, data_i   : write one entry at the tail
//   pop_i            : drop the head entry (ignored when empty)
//   flush_i          : discard all entries; wins over push/pop in the same cycle
//   head_o           : current head entry
//   count_o          : number of stored entries
//   empty_o, full_o  : occupancy flags
module instr_fetch_unit_fetch_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         entry_t = logic,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  entry_t          data_i,
  input  logic            pop_i,
  input  logic            flush_i,
  output entry_t          head_o,
  output logic [CntW-1:0] count_o,
  output logic            empty_o,
  output logic            full_o
);

  entry_t            mem_q [Depth];
  logic [PtrW-1:0]   wr_q, rd_q;
  logic [CntW-1:0]   cnt_q;
  logic              do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrW'(1);
      if (do_pop)  rd_q <= rd_q + PtrW'(1);
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end between decode and the ROMEM instruction memory.
//   CLK, RST                     : clock, asynchronous active-low reset
//   IRAM_ENABLE, IRAM_ADDRESS    : request to ROMEM, held stable until IRAM_READY
//   IRAM_READY, IRAM_DATA        : ROMEM response (ignored while IRAM_ENABLE=0)
//   redirect_valid, redirect_pc  : flush the queue and restart fetch (pc word aligned)
//   if_valid, if_ready           : decode handshake on the queue head
//   if_instr, if_pc              : head instruction and its PC
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = ins_size,
  parameter int unsigned       DATA_W   = ins_size,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              IRAM_ENABLE,
  output logic [ADDR_W-1:0] IRAM_ADDRESS,
  input  logic              IRAM_READY,
  input  logic [DATA_W-1:0] IRAM_DATA,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic              en_q, en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
  logic [ADDR_W-1:0] redir_aligned, pc_plus4, drain_target;

  logic              push, pop, full, empty, room_after_push;
  logic [CntW-1:0]   count;
  fetch_entry_t      push_entry, head;

  assign redir_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign pc_plus4      = fetch_pc_q + ADDR_W'(4);
  // A redirect arriving in the same cycle as the DRAIN completion is the newest target.
  assign drain_target  = redirect_valid ? redir_aligned : redir_pc_q;

  assign pop             = if_valid & if_ready;
  // Entries after this push = count + 1 - pop; still room if that is below DEPTH.
  assign room_after_push = pop | (count < CntW'(DEPTH - 1));

  assign push_entry.pc    = fetch_pc_q;
  assign push_entry.instr = IRAM_DATA;

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    redir_pc_d = redir_pc_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redir_aligned;
        end else if (!full) begin
          en_d    = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          if (IRAM_READY) begin
            // Response discarded; the queue is flushed so the redirect issues at once.
            addr_d     = redir_aligned;
            fetch_pc_d = redir_aligned;
          end else begin
            redir_pc_d = redir_aligned;
            state_d    = DRAIN;
          end
        end else if (IRAM_READY) begin
          push       = 1'b1;
          fetch_pc_d = pc_plus4;
          if (room_after_push) begin
            addr_d = pc_plus4;
          end else begin
            en_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (redirect_valid) redir_pc_d = redir_aligned;
        if (IRAM_READY) begin
          addr_d     = drain_target;
          fetch_pc_d = drain_target;
          state_d    = REQ;
        end
      end
      default: begin
        en_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      redir_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  instr_fetch_unit_fetch_fifo #(
    .Depth   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  assign IRAM_ENABLE  = en_q;
  assign IRAM_ADDRESS = addr_q;
  assign if_valid     = ~empty;
  assign if_instr     = head.instr;
  assign if_pc        = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: ROMEM responder with configurable delay, random decode
// back-pressure and redirects, reference stream model and protocol monitor.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IRAM_ENABLE, IRAM_READY;
  logic [31:0] IRAM_ADDRESS, IRAM_DATA;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned iram_delay = 0;
  int unsigned wait_cnt = 0;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .IRAM_ENABLE    (IRAM_ENABLE),
    .IRAM_ADDRESS   (IRAM_ADDRESS),
    .IRAM_READY     (IRAM_READY),
    .IRAM_DATA      (IRAM_DATA),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  // Program image: word at address 0 is 0x00000013 (nop).
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  // ROMEM: answers after iram_delay waiting cycles; random READY while idle must be ignored.
  always @(posedge CLK) begin
    #1;
    if (IRAM_ENABLE) begin
      if (wait_cnt >= iram_delay) begin
        IRAM_READY = 1'b1;
        IRAM_DATA  = rom_word(IRAM_ADDRESS);
        wait_cnt   = 0;
      end else begin
        IRAM_READY = 1'b0;
        IRAM_DATA  = $urandom;
        wait_cnt++;
      end
    end else begin
      IRAM_READY = 1'($urandom_range(0, 1));
      IRAM_DATA  = $urandom;
      wait_cnt   = 0;
    end
  end

  // Reference model: the decode stream is consecutive words from the last restart point.
  logic [31:0] exp_pc, fetch_exp, prev_addr;
  int          inq;
  bit          dirty, prev_pend, hs, pushed;

  always @(negedge CLK) begin
    if (!RST) begin
      exp_pc    = RESET_PC;
      fetch_exp = RESET_PC;
      inq       = 0;
      dirty     = 1'b0;
      prev_pend = 1'b0;
    end else begin
      check("if_valid_vs_model", 32'(if_valid), 32'(inq > 0));
      if (prev_pend) begin
        check("enable_held", 32'(IRAM_ENABLE), 32'd1);
        check("address_stable", IRAM_ADDRESS, prev_addr);
      end
      hs = if_valid && if_ready;
      if (hs) begin
        check("if_pc", if_pc, exp_pc);
        check("if_instr", if_instr, rom_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
      pushed = 1'b0;
      if (IRAM_ENABLE && IRAM_READY && !dirty && !redirect_valid) begin
        check("fetch_address", IRAM_ADDRESS, fetch_exp);
        fetch_exp = fetch_exp + 32'd4;
        pushed    = 1'b1;
      end
      if (redirect_valid) begin
        fetch_exp = redirect_pc & ~32'd3;
        exp_pc    = fetch_exp;
        inq       = 0;
        dirty     = IRAM_ENABLE && !IRAM_READY;
      end else begin
        if (IRAM_ENABLE && IRAM_READY) dirty = 1'b0;
        inq = inq + int'(pushed) - int'(hs);
      end
      check("queue_within_depth", 32'(inq <= int'(DEPTH)), 32'd1);
      prev_pend = IRAM_ENABLE && !IRAM_READY;
      prev_addr = IRAM_ADDRESS;
    end
  end

  task automatic wait_valid(input string name);
    int n = 0;
    while (!if_valid && n < 60) begin
      step();
      n++;
    end
    check(name, 32'(if_valid), 32'd1);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    RST = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    IRAM_READY = 1'b0; IRAM_DATA = '0;
    repeat (3) step();
    check("reset_enable", 32'(IRAM_ENABLE), 32'd0);
    check("reset_address", IRAM_ADDRESS, RESET_PC);
    check("reset_if_valid", 32'(if_valid), 32'd0);

    // Continuous stream with zero-latency ROMEM.
    iram_delay = 0;
    if_ready   = 1'b1;
    RST        = 1'b1;
    step();
    check("first_enable", 32'(IRAM_ENABLE), 32'd1);
    check("first_address", IRAM_ADDRESS, RESET_PC);
    wait_valid("first_word_timeout");
    for (int i = 0; i < 30; i++) begin
      step();
      check("continuous_valid", 32'(if_valid), 32'd1);
    end

    // Decode stall: queue fills to DEPTH and fetch stops.
    if_ready = 1'b0;
    repeat (20) step();
    check("stall_enable_low", 32'(IRAM_ENABLE), 32'd0);
    check("stall_queue_full", 32'(inq), 32'(DEPTH));
    check("stall_head_pc", if_pc, exp_pc);
    if_ready = 1'b1;
    repeat (30) step();

    // Redirect mid-request with a slow ROMEM.
    iram_delay = 3;
    n = 0;
    while (!(IRAM_ENABLE && !IRAM_READY) && n < 20) begin step(); n++; end
    redirect(32'h0000_0040);
    n = 0;
    while (!(IRAM_ENABLE && IRAM_ADDRESS == 32'h40) && n < 20) begin step(); n++; end
    check("redirect_address", IRAM_ADDRESS, 32'h0000_0040);
    wait_valid("redirect_word_timeout");
    check("redirect_first_pc", if_pc, 32'h0000_0040);
    repeat (20) step();

    // Redirect with READY, then a redirect into DRAIN, then one overwriting it.
    n = 0;
    while (!(IRAM_ENABLE && IRAM_READY) && n < 20) begin step(); n++; end
    redirect(32'h0000_0100);
    redirect(32'h0000_0180);
    redirect(32'h0000_0080);
    wait_valid("drain_word_timeout");
    check("drain_first_pc", if_pc, 32'h0000_0080);
    repeat (20) step();

    // Misaligned redirect and address wrap.
    redirect(32'h0000_0043);
    wait_valid("misaligned_timeout");
    check("misaligned_pc", if_pc, 32'h0000_0040);
    iram_delay = 0;
    redirect(32'hFFFF_FFF8);
    n = 0;
    while (!(IRAM_ENABLE && IRAM_ADDRESS == 32'h0) && n < 20) begin step(); n++; end
    check("wrap_address", IRAM_ADDRESS, 32'h0000_0000);
    repeat (10) step();

    // Random back-pressure, latency and redirects.
    for (int i = 0; i < 600; i++) begin
      iram_delay = $urandom_range(0, 3);
      if_ready   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : 32'($urandom_range(0, 4095));
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;

    // Asynchronous reset in the middle of a request.
    iram_delay = 3;
    if_ready   = 1'b0;
    n = 0;
    while (!IRAM_ENABLE && n < 20) begin step(); n++; end
    #1;
    RST = 1'b0;
    #1;
    check("async_reset_enable", 32'(IRAM_ENABLE), 32'd0);
    check("async_reset_if_valid", 32'(if_valid), 32'd0);
    check("async_reset_address", IRAM_ADDRESS, RESET_PC);
    step();
    step();
    RST = 1'b1;
    step();
    check("restart_enable", 32'(IRAM_ENABLE), 32'd1);
    check("restart_address", IRAM_ADDRESS, RESET_PC);
    if_ready = 1'b1;
    wait_valid("restart_word_timeout");
    check("restart_first_pc", if_pc, RESET_PC);
    repeat (30) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
